adsr_envelope: RTL and testbench

Per-voice ADSR envelope generator that produces the time-varying volume word for one note. It sits directly upstream of the clipping/overdrive stage and drives that stage's `max_amplitude` input. The peak for the stage's cur_amplitude scaling follows the attack/decay/sustain/release contour rather than a fixed volume. Envelope updates advance once per audio sample strobe, and all outputs are registered.

---
 rtl/synth_pkg.sv | 18 +
 rtl/env_ramp_step.sv | 40 ++++
 rtl/adsr_envelope.sv | 140 ++++++++++++++
 tb/tb_adsr_envelope.sv | 127 ++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice datapath.
//   AMP_W        : default amplitude word width (matches clipping stage)
//   ENV_STATE_W  : width of the envelope state encoding
//   env_state_t  : ADSR envelope state codes
package synth_pkg;

  localparam int AMP_W       = 31;
  localparam int ENV_STATE_W = 3;

  typedef enum logic [ENV_STATE_W-1:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_ramp_step.sv
// Combinational saturating ramp step.
//   amp     : current amplitude
//   step    : unsigned increment/decrement; 0 jumps straight to target
//   target  : saturation bound (upper bound when up=1, lower bound when up=0)
//   up      : 1 = add toward target, 0 = subtract toward target
//   amp_nxt : saturated next amplitude
//   reached : amp_nxt equals target
module env_ramp_step
  import synth_pkg::*;
#(
  parameter int W = AMP_W
) (
  input  logic [W-1:0] amp,
  input  logic [W-1:0] step,
  input  logic [W-1:0] target,
  input  logic         up,
  output logic [W-1:0] amp_nxt,
  output logic         reached
);

  // One extra bit: the sum cannot wrap, and the difference carries a sign.
  logic [W:0]        sum;
  logic signed [W:0] diff;
  logic signed [W:0] tgt_s;

  always_comb begin
    sum   = {1'b0, amp} + {1'b0, step};
    diff  = $signed({1'b0, amp}) - $signed({1'b0, step});
    tgt_s = $signed({1'b0, target});
    if (step == '0) begin
      amp_nxt = target;
    end else if (up) begin
      amp_nxt = (sum >= {1'b0, target}) ? target : sum[W-1:0];
    end else begin
      amp_nxt = (diff <= tgt_s) ? target : diff[W-1:0];
    end
    reached = (amp_nxt == target);
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator; drives the clipping stage max_amplitude.
//   clk, reset     : clock, synchronous active-high reset
//   sample_tick    : audio-rate strobe; envelope advances only when 1
//   gate           : note held (1) / released (0), sampled on ticks
//   peak_level     : attack target
//   sustain_level  : decay target / hold level (clamped to peak_level)
//   attack_step, decay_step, release_step : per-tick ramp amounts
//   max_amplitude  : registered envelope value
//   env_state      : registered state code
//   active         : registered, 1 when not IDLE
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int AMP_W = synth_pkg::AMP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic                   gate,
  input  logic [AMP_W-1:0]       peak_level,
  input  logic [AMP_W-1:0]       sustain_level,
  input  logic [AMP_W-1:0]       attack_step,
  input  logic [AMP_W-1:0]       decay_step,
  input  logic [AMP_W-1:0]       release_step,
  output logic [AMP_W-1:0]       max_amplitude,
  output logic [ENV_STATE_W-1:0] env_state,
  output logic                   active
);

  env_state_t       state_q, state_nxt;
  logic [AMP_W-1:0] amp_q, amp_nxt;
  logic             gate_q, gate_q_nxt;

  logic [AMP_W-1:0] s_eff;
  logic [AMP_W-1:0] r_step, r_target, r_amp;
  logic             r_up, r_reached;
  logic             rise;

  assign s_eff = (sustain_level > peak_level) ? peak_level : sustain_level;
  assign rise  = gate & ~gate_q;

  // Single shared ramp; operands selected by the current state.
  always_comb begin
    r_step   = '0;
    r_target = s_eff;
    r_up     = 1'b0;
    case (state_q)
      ENV_ATTACK: begin
        r_step   = attack_step;
        r_target = peak_level;
        r_up     = 1'b1;
      end
      ENV_DECAY: begin
        r_step   = decay_step;
        r_target = s_eff;
      end
      ENV_RELEASE: begin
        r_step   = release_step;
        r_target = '0;
      end
      default: ;
    endcase
  end

  env_ramp_step #(.W(AMP_W)) u_ramp (
    .amp     (amp_q),
    .step    (r_step),
    .target  (r_target),
    .up      (r_up),
    .amp_nxt (r_amp),
    .reached (r_reached)
  );

  always_comb begin
    state_nxt  = state_q;
    amp_nxt    = amp_q;
    gate_q_nxt = gate_q;
    if (!(state_q inside {ENV_IDLE, ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN, ENV_RELEASE})) begin
      // Illegal code: recover immediately, not waiting for a tick.
      state_nxt = ENV_IDLE;
      amp_nxt   = '0;
    end else if (sample_tick) begin
      gate_q_nxt = gate;
      case (state_q)
        ENV_IDLE: begin
          amp_nxt = '0;
          if (rise) state_nxt = ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!gate) begin
            state_nxt = ENV_RELEASE;
          end else begin
            amp_nxt = r_amp;
            if (r_reached) state_nxt = ENV_DECAY;
          end
        end
        ENV_DECAY: begin
          if (!gate) begin
            state_nxt = ENV_RELEASE;
          end else begin
            amp_nxt = r_amp;
            if (r_reached) state_nxt = ENV_SUSTAIN;
          end
        end
        ENV_SUSTAIN: begin
          amp_nxt = s_eff;
          if (!gate) state_nxt = ENV_RELEASE;
        end
        ENV_RELEASE: begin
          // Retrigger keeps the current level so the new attack has no click.
          if (rise) begin
            state_nxt = ENV_ATTACK;
          end else begin
            amp_nxt = r_amp;
            if (r_reached) state_nxt = ENV_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENV_IDLE;
      amp_q   <= '0;
      gate_q  <= 1'b0;
      active  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      amp_q   <= amp_nxt;
      gate_q  <= gate_q_nxt;
      active  <= (state_nxt != ENV_IDLE);
    end
  end

  assign max_amplitude = amp_q;
  assign env_state     = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope.
module tb_adsr_envelope;

  localparam int W = 31;

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_tick;
  logic         gate;
  logic [W-1:0] peak_level, sustain_level;
  logic [W-1:0] attack_step, decay_step, release_step;
  logic [W-1:0] max_amplitude;
  logic [2:0]   env_state;
  logic         active;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adsr_envelope dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .peak_level    (peak_level),
    .sustain_level (sustain_level),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .max_amplitude (max_amplitude),
    .env_state     (env_state),
    .active        (active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Check amplitude, state and active together.
  task automatic chk_out(input string tag, input int amp, input int st);
    chk({tag, ".amp"}, {1'b0, max_amplitude}, amp);
    chk({tag, ".state"}, {29'd0, env_state}, st);
    chk({tag, ".active"}, {31'd0, active}, (st != 0) ? 1 : 0);
  endtask

  // One tick: strobe for a single clk, then sample on the following negedge.
  task automatic tick();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_tick = 1'b0; gate = 1'b0;
    peak_level = 1000; sustain_level = 600;
    attack_step = 300; decay_step = 150; release_step = 250;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_out("reset", 0, 0);

    // Full contour
    gate = 1'b1;
    tick(); chk_out("rise", 0, 1);
    tick(); chk_out("atk1", 300, 1);
    tick(); chk_out("atk2", 600, 1);
    tick(); chk_out("atk3", 900, 1);
    tick(); chk_out("atk4", 1000, 2);
    tick(); chk_out("dec1", 850, 2);
    tick(); chk_out("dec2", 700, 2);
    tick(); chk_out("dec3", 600, 3);
    tick(); chk_out("sus", 600, 3);
    gate = 1'b0;
    tick(); chk_out("rel0", 600, 4);
    tick(); chk_out("rel1", 350, 4);
    tick(); chk_out("rel2", 100, 4);
    tick(); chk_out("rel3", 0, 0);

    // Zero attack step jump and sustain clamp
    sustain_level = 5000; attack_step = 0;
    gate = 1'b1;
    tick(); chk_out("rise2", 0, 1);
    tick(); chk_out("zstep", 1000, 2);
    tick(); chk_out("clamp", 1000, 3);
    sustain_level = 400;
    tick(); chk_out("sus_live", 400, 3);

    // Ticks held off while gate toggles: nothing moves
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) gate = ~gate;
    end
    gate = 1'b1;
    @(negedge clk);
    chk_out("hold", 400, 3);

    // Release retrigger continues from current level
    sustain_level = 900;
    tick(); chk_out("sus900", 900, 3);
    gate = 1'b0; release_step = 200;
    tick(); chk_out("relA", 900, 4);
    tick(); chk_out("relB", 700, 4);
    gate = 1'b1; attack_step = 100;
    tick(); chk_out("retrig", 700, 1);
    tick(); chk_out("retrig_atk", 800, 1);

    // Overflow guard at full-scale peak
    peak_level = 31'h7FFF_FFFF;
    attack_step = 31'h4000_0000 - 31'd795;
    tick(); chk_out("ovf_pre", 32'h4000_0005, 1);
    attack_step = 31'h4000_0000;
    tick(); chk_out("ovf_sat", 32'h7FFF_FFFF, 2);

    // Reset mid-RELEASE with a tick on the same cycle
    gate = 1'b0;
    tick(); chk_out("relC", 32'h7FFF_FFFF, 4);
    @(negedge clk) begin reset = 1'b1; sample_tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; sample_tick = 1'b0; end
    chk_out("rst_mid", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
